// File: rtl/processor_core_param_pkg.sv
// Shared encodings for the parametrised accumulator processor: FSM states and opcodes.
package processor_core_param_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_OUTWAIT = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    // Opcodes are decoded on 4 bits; wider opcode fields with upper bits set act as NOP.
    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'h0;
    localparam opcode_t OP_LDI  = 4'h1;
    localparam opcode_t OP_LD   = 4'h2;
    localparam opcode_t OP_ST   = 4'h3;
    localparam opcode_t OP_ADD  = 4'h4;
    localparam opcode_t OP_SUB  = 4'h5;
    localparam opcode_t OP_ADDI = 4'h6;
    localparam opcode_t OP_JMP  = 4'h7;
    localparam opcode_t OP_JZ   = 4'h8;
    localparam opcode_t OP_JNZ  = 4'h9;
    localparam opcode_t OP_OUT  = 4'hA;
    localparam opcode_t OP_AND  = 4'hB;
    localparam opcode_t OP_SHR  = 4'hC;
    localparam opcode_t OP_HALT = 4'hF;

endpackage

// File: rtl/processor_core_param_alu.sv
// Combinational ALU: computes the new accumulator and flags for the instruction in EXECUTE.
module processor_core_param_alu
    import processor_core_param_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OPD_W  = 12
) (
    input  opcode_t           op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] mem,
    input  logic [OPD_W-1:0]  imm,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry,
    output logic              acc_we,
    output logic              carry_we
);

    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W:0]   sum;

    assign imm_zext = DATA_W'(imm);
    assign imm_sext = DATA_W'($signed(imm));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        result   = acc;
        carry    = 1'b0;
        acc_we   = 1'b0;
        carry_we = 1'b0;
        sum      = '0;
        case (op)
            OP_LDI: begin
                result = imm_zext;
                acc_we = 1'b1;
            end
            OP_LD: begin
                result = mem;
                acc_we = 1'b1;
            end
            OP_ADD: begin
                sum      = {1'b0, acc} + {1'b0, mem};
                result   = sum[DATA_W-1:0];
                carry    = sum[DATA_W];
                acc_we   = 1'b1;
                carry_we = 1'b1;
            end
            OP_SUB: begin
                // The extra top bit of the widened difference is the borrow.
                sum      = {1'b0, acc} - {1'b0, mem};
                result   = sum[DATA_W-1:0];
                carry    = sum[DATA_W];
                acc_we   = 1'b1;
                carry_we = 1'b1;
            end
            OP_ADDI: begin
                sum      = {1'b0, acc} + {1'b0, imm_sext};
                result   = sum[DATA_W-1:0];
                carry    = sum[DATA_W];
                acc_we   = 1'b1;
                carry_we = 1'b1;
            end
            OP_AND: begin
                result = acc & mem;
                acc_we = 1'b1;
            end
            OP_SHR: begin
                result = acc >> 1;
                acc_we = 1'b1;
            end
            default: ;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/processor_core_param.sv
// Multi-cycle accumulator processor: FETCH/DECODE/EXECUTE with host program load and OUT handshake.
module processor_core_param
    import processor_core_param_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 8,
    parameter int OPC_W   = 4,
    parameter int OPD_W   = 12,
    parameter int DMEM_AW = 6,
    localparam int INSTR_W = OPC_W + OPD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               halted,
    output logic [DATA_W-1:0]  data_output,
    output logic [PC_W-1:0]    pc_output,
    output logic [2:0]         current_state_output,
    output logic [OPC_W-1:0]   opcode_bus_output,
    output logic [OPD_W-1:0]   operand_bus_output
);

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]  mem_q;
    logic [INSTR_W-1:0] ir;
    logic               z_flag;
    logic               c_flag;

    logic [INSTR_W-1:0] imem [2**PC_W];
    logic [DATA_W-1:0]  dmem [2**DMEM_AW];

    logic [OPC_W-1:0]   ir_opc;
    logic [OPD_W-1:0]   ir_opd;
    logic [DMEM_AW-1:0] dmem_addr;
    opcode_t            op;
    logic               loadable;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;

    logic [DATA_W-1:0]  alu_result;
    logic               alu_zero;
    logic               alu_carry;
    logic               alu_acc_we;
    logic               alu_carry_we;

    assign ir_opc        = ir[INSTR_W-1 -: OPC_W];
    assign ir_opd        = ir[OPD_W-1:0];
    assign dmem_addr     = ir_opd[DMEM_AW-1:0];
    assign op            = ((ir_opc >> 4) == '0) ? opcode_t'(ir_opc) : OP_NOP;
    assign loadable      = (state == S_IDLE) || (state == S_HALT);
    assign branch_target = PC_W'(ir_opd);
    assign branch_taken  = (op == OP_JMP) || (op == OP_JZ && z_flag) || (op == OP_JNZ && !z_flag);

    processor_core_param_alu #(
        .DATA_W (DATA_W),
        .OPD_W  (OPD_W)
    ) u_alu (
        .op       (op),
        .acc      (acc),
        .mem      (mem_q),
        .imm      (ir_opd),
        .result   (alu_result),
        .zero     (alu_zero),
        .carry    (alu_carry),
        .acc_we   (alu_acc_we),
        .carry_we (alu_carry_we)
    );

    // NOTE: memories have no reset; clearing them would block RAM inference and hosts reload anyway.
    // A reset drops state to IDLE immediately, so an aborted ST never reaches the write below.
    always_ff @(posedge clk) begin
        if (prog_we && loadable)
            imem[prog_addr] <= prog_wdata;
        if (state == S_EXECUTE && op == OP_ST)
            dmem[dmem_addr] <= acc;
        if (state == S_DECODE)
            mem_q <= dmem[dmem_addr];
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pc        <= '0;
            acc       <= '0;
            ir        <= '0;
            z_flag    <= 1'b0;
            c_flag    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state  <= S_FETCH;
                        pc     <= '0;
                        acc    <= '0;
                        halted <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir    <= imem[pc];
                    state <= S_DECODE;
                end
                S_DECODE: state <= S_EXECUTE;
                S_EXECUTE: begin
                    pc    <= branch_taken ? branch_target : pc + PC_W'(1);
                    state <= S_FETCH;
                    if (alu_acc_we) begin
                        acc    <= alu_result;
                        z_flag <= alu_zero;
                    end
                    if (alu_carry_we)
                        c_flag <= alu_carry;
                    if (op == OP_OUT) begin
                        out_data  <= acc;
                        out_valid <= 1'b1;
                        state     <= S_OUTWAIT;
                    end else if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end
                end
                S_OUTWAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign data_output          = acc;
    assign pc_output            = pc;
    assign current_state_output = state;
    assign opcode_bus_output    = ir_opc;
    assign operand_bus_output   = ir_opd;

endmodule

// File: tb/tb_processor_core_param.sv
// Directed bench for processor_core_param: a default build and a DATA_W=12 build share all inputs.
module tb_processor_core_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [15:0] prog_wdata = '0;
    logic        out_ready = 1'b1;

    logic [15:0] out_data, data_output;
    logic        out_valid, halted;
    logic [7:0]  pc_output;
    logic [2:0]  state;
    logic [3:0]  opc;
    logic [11:0] opd;

    logic [11:0] w12_out_data, w12_data;
    logic        w12_out_valid, w12_halted;
    logic [7:0]  w12_pc;
    logic [2:0]  w12_state;
    logic [3:0]  w12_opc;
    logic [11:0] w12_opd;

    int n_cmp = 0;
    int n_err = 0;
    int cycles;

    logic [15:0] prog [16];
    int          prog_len;

    always #5 clk = ~clk;

    processor_core_param dut (
        .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .halted(halted), .data_output(data_output), .pc_output(pc_output),
        .current_state_output(state), .opcode_bus_output(opc), .operand_bus_output(opd)
    );

    processor_core_param #(.DATA_W(12)) dut12 (
        .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .out_data(w12_out_data), .out_valid(w12_out_valid), .out_ready(out_ready),
        .halted(w12_halted), .data_output(w12_data), .pc_output(w12_pc),
        .current_state_output(w12_state), .opcode_bus_output(w12_opc), .operand_bus_output(w12_opd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] operand);
        return {op, operand};
    endfunction

    task automatic load_word(input logic [7:0] a, input logic [15:0] w, input logic go);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = w;
        start      = go;
        @(negedge clk);
        prog_we = 1'b0;
        start   = 1'b0;
    endtask

    // Word 0 goes last, together with start, so a dropped simultaneous write shows up.
    task automatic run_prog();
        for (int i = 1; i < prog_len; i++)
            load_word(8'(i), prog[i], 1'b0);
        load_word(8'd0, prog[0], 1'b1);
    endtask

    task automatic wait_halt(input string tag, input int budget, output int n);
        n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_halted"}, 32'(halted), 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_pc", 32'(pc_output), 0);
        check("rst_acc", 32'(data_output), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_halted", 32'(halted), 0);
        reset = 1'b1;
        @(negedge clk);

        // LDI 7; OUT; HALT with the sink stalled for 4 cycles
        prog[0] = ins(4'h1, 12'd7);
        prog[1] = ins(4'hA, 12'd0);
        prog[2] = ins(4'hF, 12'd0);
        prog_len  = 3;
        out_ready = 1'b0;
        run_prog();
        repeat (6) @(negedge clk);
        check("out_enter_state", 32'(state), 4);
        for (int i = 0; i < 4; i++) begin
            check("out_hold_valid", 32'(out_valid), 1);
            check("out_hold_data", 32'(out_data), 7);
            @(negedge clk);
        end
        check("out_w12_data", 32'(w12_out_data), 7);
        check("out_still_wait", 32'(state), 4);
        out_ready = 1'b1;
        @(negedge clk);
        check("out_leave_state", 32'(state), 1);
        check("out_cleared", 32'(out_valid), 0);
        check("out_w12_cleared", 32'(w12_out_valid), 0);
        check("out_data_kept", 32'(out_data), 7);
        wait_halt("out", 50, cycles);
        check("out_halt_cycles", 32'(cycles), 3);

        // LDI 5; ADDI -1; JNZ 1; HALT: five loop iterations
        prog[0] = ins(4'h1, 12'd5);
        prog[1] = ins(4'h6, 12'hFFF);
        prog[2] = ins(4'h9, 12'd1);
        prog[3] = ins(4'hF, 12'd0);
        prog_len = 4;
        run_prog();
        wait_halt("loop", 200, cycles);
        check("loop_cycles", 32'(cycles), 36);
        check("loop_acc", 32'(data_output), 0);
        check("loop_state", 32'(state), 5);
        check("loop_z", 32'(dut.z_flag), 1);

        // Carry out of ADDI at DATA_W=12; the 16-bit build simply reaches 0x1000
        prog[0] = ins(4'h1, 12'hFFF);
        prog[1] = ins(4'h3, 12'd0);
        prog[2] = ins(4'h1, 12'd0);
        prog[3] = ins(4'h4, 12'd0);
        prog[4] = ins(4'h6, 12'd1);
        prog[5] = ins(4'hF, 12'd0);
        prog_len = 6;
        run_prog();
        wait_halt("carry", 200, cycles);
        check("carry_cycles", 32'(cycles), 18);
        check("carry_w12_halted", 32'(w12_halted), 1);
        check("carry_w12_acc", 32'(w12_data), 0);
        check("carry_w12_c", 32'(dut12.c_flag), 1);
        check("carry_w12_z", 32'(dut12.z_flag), 1);
        check("carry_w16_acc", 32'(data_output), 32'h1000);
        check("carry_w16_c", 32'(dut.c_flag), 0);

        // JMP 0xFF with NOP at 0xFF: pc wraps to 0 and word 0 is fetched again
        prog[0] = ins(4'h7, 12'h0FF);
        prog_len = 1;
        load_word(8'hFF, 16'h0000, 1'b0);
        run_prog();
        repeat (3) @(negedge clk);
        check("jmp_target", 32'(pc_output), 32'hFF);
        @(negedge clk);
        check("jmp_nop_decode", 32'(opc), 0);
        repeat (2) @(negedge clk);
        check("jmp_wrap_pc", 32'(pc_output), 0);
        check("jmp_w12_pc", 32'(w12_pc), 0);
        @(negedge clk);
        check("jmp_again_state", 32'(state), 2);
        check("jmp_again_opc", 32'(opc), 7);
        check("jmp_again_opd", 32'(opd), 32'hFF);
        check("jmp_w12_opd", 32'({w12_opc, w12_opd}), 32'h70FF);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Host write and start while running are both ignored
        prog[0] = ins(4'h1, 12'd1);
        prog[1] = ins(4'h6, 12'd2);
        prog[2] = ins(4'h6, 12'd4);
        prog[3] = ins(4'h6, 12'd8);
        prog[4] = ins(4'hF, 12'd0);
        prog_len = 5;
        run_prog();
        repeat (6) @(negedge clk);
        check("busy_state", 32'(state), 1);
        load_word(8'd3, 16'h0000, 1'b1);
        wait_halt("busy", 100, cycles);
        check("busy_cycles", 32'(cycles), 8);
        check("busy_acc", 32'(data_output), 15);

        // Reset in the middle of ADD, then confirm dmem survived
        prog[0] = ins(4'h1, 12'd9);
        prog[1] = ins(4'h3, 12'd3);
        prog[2] = ins(4'h1, 12'd4);
        prog[3] = ins(4'h4, 12'd3);
        prog[4] = ins(4'h3, 12'd3);
        prog[5] = ins(4'hF, 12'd0);
        prog_len = 6;
        run_prog();
        repeat (11) @(negedge clk);
        check("mid_state", 32'(state), 3);
        check("mid_opc", 32'(opc), 4);
        check("mid_acc", 32'(data_output), 4);
        reset = 1'b0;
        #1;
        check("abort_state", 32'(state), 0);
        check("abort_pc", 32'(pc_output), 0);
        check("abort_acc", 32'(data_output), 0);
        check("abort_ir", 32'({opc, opd}), 0);
        check("abort_out", 32'({out_valid, out_data}), 0);
        check("abort_halted", 32'(halted), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        prog[0] = ins(4'h2, 12'd3);
        prog[1] = ins(4'hA, 12'd0);
        prog[2] = ins(4'hF, 12'd0);
        prog_len = 3;
        run_prog();
        wait_halt("dmem", 100, cycles);
        check("dmem_cycles", 32'(cycles), 10);
        check("dmem_out", 32'(out_data), 9);
        check("dmem_acc", 32'(data_output), 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
